// File: rtl/sdram_controller.sv
// Host-side initiator: one 4-beat read or write burst per request on the multiplexed-address SDRAM pins.
// Latency: accept at edge E, ROW pins after E, rd_valid/wr_done in the cycle after E+8; a new burst can start every 9 cycles.
// Backpressure: req_ready is high only while idle or recovering; requests offered at any other time are ignored, not queued.
module sdram_controller #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic                            req_write,
    input  logic [2*ADDR_WIDTH-1:0]         req_addr,
    input  logic [DATA_WIDTH*BURST_LEN-1:0] wr_data,
    output logic [DATA_WIDTH*BURST_LEN-1:0] rd_data,
    output logic                            rd_valid,
    output logic                            wr_done,
    output logic [ADDR_WIDTH-1:0]           partial_address_bus,
    output logic                            chip_enable_not,
    output logic                            write_not,
    output logic                            ras_not,
    output logic                            cas_not,
    inout  wire  [DATA_WIDTH-1:0]           data
);

    localparam int BW = DATA_WIDTH * BURST_LEN;

    typedef enum logic [2:0] {
        S_IDLE, S_ROW, S_GAP1, S_COL, S_GAP2, S_DATA, S_RECOVER
    } state_t;

    // Request captured at accept so the host may change its inputs freely afterwards.
    typedef struct packed {
        logic                    write;
        logic [2*ADDR_WIDTH-1:0] addr;
        logic [BW-1:0]           wdat;
    } req_t;

    state_t                state, state_nxt;
    req_t                  req_q, req_nxt;
    logic [1:0]            beat, beat_nxt;
    logic                  accept;
    logic [BW-1:0]         cap;

    // Next-cycle pin values; every output is registered from these.
    logic                  ready_nxt, rdv_nxt, wrd_nxt;
    logic                  ce_n_nxt, we_n_nxt, ras_n_nxt, cas_n_nxt;
    logic [ADDR_WIDTH-1:0] pab_nxt;
    logic                  drive, drive_nxt;
    logic [DATA_WIDTH-1:0] dq, dq_nxt;

    // State, beat counter and latched request.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
            beat  <= 2'd0;
            req_q <= '0;
        end else begin
            state <= state_nxt;
            beat  <= beat_nxt;
            req_q <= req_nxt;
        end
    end

    // Next state, and the pin values that the next state will present.
    always_comb begin
        state_nxt = state;
        req_nxt   = req_q;
        beat_nxt  = 2'd0;
        accept    = req_valid && req_ready;
        if (accept) begin
            req_nxt = {req_write, req_addr, wr_data};
        end
        case (state)
            S_IDLE:    if (accept) state_nxt = S_ROW;
            S_ROW:     state_nxt = S_GAP1;
            S_GAP1:    state_nxt = S_COL;
            S_COL:     state_nxt = S_GAP2;
            S_GAP2:    state_nxt = S_DATA;
            S_DATA: begin
                beat_nxt = beat + 2'd1;
                if (beat == 2'd3) state_nxt = S_RECOVER;
            end
            // Recovery doubles as an accept slot so bursts can issue back to back.
            S_RECOVER: state_nxt = accept ? S_ROW : S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase

        ready_nxt = 1'b0;
        rdv_nxt   = 1'b0;
        wrd_nxt   = 1'b0;
        ce_n_nxt  = 1'b1;
        we_n_nxt  = 1'b1;
        ras_n_nxt = 1'b1;
        cas_n_nxt = 1'b1;
        pab_nxt   = '0;
        drive_nxt = 1'b0;
        dq_nxt    = dq;
        case (state_nxt)
            S_IDLE:    ready_nxt = 1'b1;
            S_ROW: begin
                ce_n_nxt  = 1'b0;
                ras_n_nxt = 1'b0;
                pab_nxt   = req_nxt.addr[2*ADDR_WIDTH-1:ADDR_WIDTH];
            end
            S_GAP1, S_GAP2: ce_n_nxt = 1'b0;
            S_COL: begin
                ce_n_nxt  = 1'b0;
                we_n_nxt  = ~req_nxt.write;
                cas_n_nxt = 1'b0;
                pab_nxt   = req_nxt.addr[ADDR_WIDTH-1:0];
            end
            S_DATA: begin
                ce_n_nxt  = 1'b0;
                we_n_nxt  = ~req_nxt.write;
                drive_nxt = req_nxt.write;
                dq_nxt    = req_nxt.wdat[int'(beat_nxt)*DATA_WIDTH +: DATA_WIDTH];
            end
            S_RECOVER: begin
                ready_nxt = 1'b1;
                rdv_nxt   = ~req_nxt.write;
                wrd_nxt   = req_nxt.write;
            end
            default: ready_nxt = 1'b0;
        endcase
    end

    // Registered outputs, plus read capture at the edge that ends each read beat.
    always_ff @(posedge clock) begin
        if (reset) begin
            req_ready           <= 1'b1;
            rd_valid            <= 1'b0;
            wr_done             <= 1'b0;
            chip_enable_not     <= 1'b1;
            write_not           <= 1'b1;
            ras_not             <= 1'b1;
            cas_not             <= 1'b1;
            partial_address_bus <= '0;
            drive               <= 1'b0;
            dq                  <= '0;
            cap                 <= '0;
            rd_data             <= '0;
        end else begin
            req_ready           <= ready_nxt;
            rd_valid            <= rdv_nxt;
            wr_done             <= wrd_nxt;
            chip_enable_not     <= ce_n_nxt;
            write_not           <= we_n_nxt;
            ras_not             <= ras_n_nxt;
            cas_not             <= cas_n_nxt;
            partial_address_bus <= pab_nxt;
            drive               <= drive_nxt;
            dq                  <= dq_nxt;
            if (state == S_DATA && !req_q.write) begin
                // Shift right so beat 0 ends up in the lowest byte after four beats.
                cap <= {data, cap[BW-1:DATA_WIDTH]};
                if (beat == 2'd3) begin
                    rd_data <= {data, cap[BW-1:DATA_WIDTH]};
                end
            end
        end
    end

    assign data = drive ? dq : {DATA_WIDTH{1'bz}};

endmodule
